alu_seq: RTL

Parametrised, registered successor to the team's combinational 8-bit ALU. Adds a valid/ready handshake on both sides, an iterative shifter (one bit per cycle, full shift range), shift-left, set-less-than, and signed-overflow, negative and error flags. Sits between the operand/opcode capture logic (UART command decoder) and the result transmitter. Holds each result until the consumer takes it.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_comb_core.sv | 72 +++++++
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - opcode values (MIPS funct encoding, 6 bits)
//   - handshake FSM state encoding (IDLE / SHIFT / HOLD, 2 bits)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int NB_OP_DEFAULT = 6;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational datapath for all non-shift operations plus the common
// flag generation. For shift opcodes the already-shifted value arrives on
// i_shift_result and is passed through, so zero/negative come from one place.
// Ports:
//   i_data_a, i_data_b  operands
//   i_op                opcode
//   i_shift_result      final value of a shift operation
//   o_data              result
//   o_carry, o_zero, o_overflow, o_negative, o_error  flags
// -----------------------------------------------------------------------------
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_shift_result,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_overflow,
    output logic               o_negative,
    output logic               o_error
);

    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA:0]   sum_ext;
    logic [NB_DATA:0]   diff_ext;
    logic [NB_DATA-1:0] result;

    // Top bit of diff_ext is the borrow out of the unsigned subtraction.
    assign sum_ext  = {1'b0, i_data_a} + {1'b0, i_data_b};
    assign diff_ext = {1'b0, i_data_a} - {1'b0, i_data_b};

    always_comb begin
        result     = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_error    = 1'b0;
        case (i_op)
            NB_OP'(OP_ADD): begin
                {o_carry, result} = sum_ext;
                o_overflow = (i_data_a[MSB] == i_data_b[MSB]) && (sum_ext[MSB] != i_data_a[MSB]);
            end
            NB_OP'(OP_SUB): begin
                {o_carry, result} = diff_ext;
                o_overflow = (i_data_a[MSB] != i_data_b[MSB]) && (diff_ext[MSB] != i_data_a[MSB]);
            end
            NB_OP'(OP_AND):  result = i_data_a & i_data_b;
            NB_OP'(OP_OR):   result = i_data_a | i_data_b;
            NB_OP'(OP_XOR):  result = i_data_a ^ i_data_b;
            NB_OP'(OP_NOR):  result = ~(i_data_a | i_data_b);
            NB_OP'(OP_SLT):  result = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            NB_OP'(OP_SLTU): result = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            NB_OP'(OP_SLL),
            NB_OP'(OP_SRL),
            NB_OP'(OP_SRA):  result = i_shift_result;
            default:         o_error = 1'b1;
        endcase
    end

    assign o_data     = result;
    assign o_zero     = (result == '0);
    assign o_negative = result[MSB];

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered ALU with valid/ready handshakes on both sides. Non-shift ops
// finish in one cycle; shifts iterate one bit per cycle (latency = amount).
// A result is held stable until the consumer takes it.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid / o_ready     input handshake (o_ready only in IDLE)
//   i_data_a, i_data_b    operands (shift amount = i_data_b[NB_SHAMT-1:0])
//   i_op                  opcode
//   o_valid / i_ready     output handshake (o_valid only in HOLD)
//   o_data + flags        registered result and flags
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = NB_OP_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_overflow,
    output logic               o_negative,
    output logic               o_error
);

    localparam int NB_SHAMT = $clog2(NB_DATA);

    state_t               state_reg, state_next;
    logic [NB_OP-1:0]     op_reg;
    logic [NB_DATA-1:0]   work_reg;
    logic [NB_SHAMT-1:0]  count_reg;
    logic [NB_DATA-1:0]   data_reg;
    logic                 carry_reg, zero_reg, overflow_reg, negative_reg, error_reg;

    logic [NB_SHAMT-1:0]  shamt_in;
    logic                 in_is_shift;
    logic                 start_shift;
    logic                 last_shift;
    logic [NB_DATA-1:0]   sll_step, srl_step, sra_step, work_shifted;
    logic [NB_OP-1:0]     core_op;
    logic [NB_DATA-1:0]   core_shift_result;
    logic [NB_DATA-1:0]   core_data;
    logic                 core_carry, core_zero, core_overflow, core_negative, core_error;

    assign shamt_in    = i_data_b[NB_SHAMT-1:0];
    assign in_is_shift = (i_op == NB_OP'(OP_SLL)) || (i_op == NB_OP'(OP_SRL)) ||
                         (i_op == NB_OP'(OP_SRA));
    // A zero-amount shift skips SHIFT and completes like any single-cycle op.
    assign start_shift = in_is_shift && (shamt_in != '0);
    assign last_shift  = (count_reg == NB_SHAMT'(1));

    // One-bit shift steps of the work register.
    genvar gi;
    generate
        for (gi = 0; gi < NB_DATA; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign sll_step[gi] = 1'b0;
            end else begin : g_lsb_n
                assign sll_step[gi] = work_reg[gi-1];
            end
            if (gi == NB_DATA-1) begin : g_msb
                assign srl_step[gi] = 1'b0;
                assign sra_step[gi] = work_reg[gi];
            end else begin : g_msb_n
                assign srl_step[gi] = work_reg[gi+1];
                assign sra_step[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        work_shifted = sra_step;
        if (op_reg == NB_OP'(OP_SLL)) begin
            work_shifted = sll_step;
        end else if (op_reg == NB_OP'(OP_SRL)) begin
            work_shifted = srl_step;
        end
    end

    // In IDLE the core sees the live inputs (immediate completion); in SHIFT
    // it sees the captured opcode and the work register after its final step.
    assign core_op           = (state_reg == ST_SHIFT) ? op_reg : i_op;
    assign core_shift_result = (state_reg == ST_SHIFT) ? work_shifted : i_data_a;

    alu_comb_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_core (
        .i_data_a       (i_data_a),
        .i_data_b       (i_data_b),
        .i_op           (core_op),
        .i_shift_result (core_shift_result),
        .o_data         (core_data),
        .o_carry        (core_carry),
        .o_zero         (core_zero),
        .o_overflow     (core_overflow),
        .o_negative     (core_negative),
        .o_error        (core_error)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_valid) begin
                    state_next = start_shift ? ST_SHIFT : ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decode straight from state
    always_comb begin
        o_ready = (state_reg == ST_IDLE);
        o_valid = (state_reg == ST_HOLD);
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_reg       <= '0;
            work_reg     <= '0;
            count_reg    <= '0;
            data_reg     <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            negative_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_reg    <= i_op;
                        work_reg  <= i_data_a;
                        count_reg <= shamt_in;
                        if (!start_shift) begin
                            data_reg     <= core_data;
                            carry_reg    <= core_carry;
                            zero_reg     <= core_zero;
                            overflow_reg <= core_overflow;
                            negative_reg <= core_negative;
                            error_reg    <= core_error;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg  <= work_shifted;
                    count_reg <= count_reg - NB_SHAMT'(1);
                    if (last_shift) begin
                        data_reg     <= core_data;
                        carry_reg    <= core_carry;
                        zero_reg     <= core_zero;
                        overflow_reg <= core_overflow;
                        negative_reg <= core_negative;
                        error_reg    <= core_error;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data     = data_reg;
    assign o_carry    = carry_reg;
    assign o_zero     = zero_reg;
    assign o_overflow = overflow_reg;
    assign o_negative = negative_reg;
    assign o_error    = error_reg;

endmodule
